mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Arbiter between the icache and dcache miss/writeback ports and one shared
// RAM port. One requester owns the RAM at a time. The grant is held until the
// RAM answers ACCESS or ERROR, or until a grant has run TIMEOUT cycles without
// an answer. The dcache wins ties. The icache is forced in after STARVE_MAX
// consecutive dcache grants taken while it was waiting.
//
// Handshake: a requester raises its enable(s) and keeps address/data stable
// while its wait output is 1. The transfer completes in the one cycle where
// wait drops to 0 while the enable is still high. Read data on iload/dload is
// valid in that cycle only. Arbitration costs one IDLE cycle: a request
// present in cycle N drives the RAM in cycle N+1.
//
// Ports
//   CLK, RST         clock (rising edge), synchronous active-high reset
//   iREN/iaddr       icache read request and word address
//   iload/iwait      icache read data and stall
//   dREN/dWEN        dcache read / write request (write wins if both)
//   daddr/dstore     dcache address and write data
//   dload/dwait      dcache read data and stall
//   ramREN/ramWEN    RAM enables, driven only by the granted requester
//   ramaddr/ramstore RAM address and write data
//   ramload/ramstate RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err              sticky: an ERROR or a timeout was seen since reset
//   o_dbg_state      FSM state for observation: 0 IDLE, 1 GNT_I, 2 GNT_D
// ----------------------------------------------------------------------------
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  word_t       iaddr,
   output word_t       iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  word_t       daddr,
   input  word_t       dstore,
   output word_t       dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output word_t       ramaddr,
   output word_t       ramstore,
   input  word_t       ramload,
   input  ramstate_t   ramstate,
   output logic        err,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

   state_t     r_state;
   logic [3:0] r_starve_cnt;
   logic [7:0] r_tmo_cnt;
   logic       r_err;

   logic w_dreq;
   logic w_gnt_req;
   logic w_take_d;

   assign w_dreq      = dREN | dWEN;
   // Whether the current owner still asserts any enable.
   assign w_gnt_req   = (r_state == GNT_D) ? w_dreq : iREN;
   // The dcache wins unless the icache has been passed over STARVE_MAX times.
   assign w_take_d    = w_dreq && ((r_starve_cnt < STARVE_LIM) || !iREN);
   assign err         = r_err;
   assign o_dbg_state = r_state;

   // Outputs are live functions of the state and the granted requester.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iload    = '0;
      dload    = '0;
      iwait    = iREN;
      dwait    = w_dreq;
      unique case (r_state)
         GNT_D: begin
            // A withdrawn request leaves the RAM idle; dwait already follows
            // the (now low) request.
            if (w_dreq) begin
               ramREN   = dREN & ~dWEN;
               ramWEN   = dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ramstate == ACCESS) begin
                  dwait = 1'b0;
                  dload = ramload;
               end else if (ramstate == ERROR) begin
                  dwait = 1'b0;
               end else begin
                  dwait = 1'b1;
                  dload = ramload;
               end
            end
         end
         GNT_I: begin
            if (iREN) begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ramstate == ACCESS) begin
                  iwait = 1'b0;
                  iload = ramload;
               end else if (ramstate == ERROR) begin
                  iwait = 1'b0;
               end else begin
                  iwait = 1'b1;
                  iload = ramload;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
         r_tmo_cnt    <= '0;
         r_err        <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_tmo_cnt <= '0;
               if (w_take_d) begin
                  r_state <= GNT_D;
                  if (iREN) begin
                     if (r_starve_cnt < STARVE_LIM) r_starve_cnt <= r_starve_cnt + 4'd1;
                  end else begin
                     r_starve_cnt <= '0;
                  end
               end else if (iREN) begin
                  r_state      <= GNT_I;
                  r_starve_cnt <= '0;
               end else begin
                  r_starve_cnt <= '0;
               end
            end
            GNT_I, GNT_D: begin
               if (!w_gnt_req) begin
                  r_state <= IDLE;
               end else if (ramstate == ACCESS) begin
                  r_state <= IDLE;
               end else if (ramstate == ERROR) begin
                  r_state <= IDLE;
                  r_err   <= 1'b1;
               end else if (r_tmo_cnt == TMO_LAST) begin
                  // Abort; the requester keeps waiting and is re-arbitrated.
                  r_state <= IDLE;
                  r_err   <= 1'b1;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios followed by a randomized run. Every cycle all DUT
// outputs are compared with a reference model that tracks only who owns the
// RAM, how long the grant has lasted, how often the icache was passed over,
// and the sticky error.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int SM  = 4;
   localparam int TMO = 8;

   // clock / reset
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   // DUT connections
   logic       iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   word_t      iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
   ramstate_t  ramstate = FREE;
   word_t      iload, dload, ramaddr, ramstore;
   logic       iwait, dwait, ramREN, ramWEN, err;
   logic [1:0] dbg_state;

   mem_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err),
      .o_dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model: owner 0 = nobody, 1 = icache, 2 = dcache
   int   m_owner  = 0;
   int   m_starve = 0;
   int   m_age    = 0;
   logic m_err    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare all outputs against the model, away from the active edge.
   task automatic sample();
      logic  e_ren, e_wen, e_iwait, e_dwait, req;
      word_t e_addr, e_store, e_iload, e_dload;
      @(negedge CLK);
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_iload = 0; e_dload = 0;
      e_iwait = iREN;
      e_dwait = dREN | dWEN;
      if (m_owner != 0) begin
         req = (m_owner == 2) ? (dREN | dWEN) : iREN;
         if (!req) begin
            if (m_owner == 2) e_dwait = 0; else e_iwait = 0;
         end else begin
            if (m_owner == 2) begin
               e_wen   = dWEN;
               e_ren   = dREN && !dWEN;
               e_addr  = daddr;
               e_store = dstore;
               e_dwait = !(ramstate == ACCESS || ramstate == ERROR);
               e_dload = (ramstate == ERROR) ? 32'h0 : ramload;
            end else begin
               e_ren   = 1;
               e_addr  = iaddr;
               e_iwait = !(ramstate == ACCESS || ramstate == ERROR);
               e_iload = (ramstate == ERROR) ? 32'h0 : ramload;
            end
         end
      end
      chk("state",    32'(dbg_state), 32'(m_owner));
      chk("ramREN",   32'(ramREN),    32'(e_ren));
      chk("ramWEN",   32'(ramWEN),    32'(e_wen));
      chk("ramaddr",  ramaddr,        e_addr);
      chk("ramstore", ramstore,       e_store);
      chk("iload",    iload,          e_iload);
      chk("dload",    dload,          e_dload);
      chk("iwait",    32'(iwait),     32'(e_iwait));
      chk("dwait",    32'(dwait),     32'(e_dwait));
      chk("err",      32'(err),       32'(m_err));
   endtask

   // Clock edge: advance the model with the inputs that were just sampled.
   task automatic tick();
      logic dreq, req;
      @(posedge CLK);
      dreq = dREN | dWEN;
      if (RST) begin
         m_owner = 0; m_starve = 0; m_age = 0; m_err = 0;
      end else if (m_owner == 0) begin
         m_age = 0;
         if (dreq && (m_starve < SM || !iREN)) begin
            m_owner  = 2;
            m_starve = iREN ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
         end else begin
            if (iREN) m_owner = 1;
            m_starve = 0;
         end
      end else begin
         req = (m_owner == 2) ? dreq : iREN;
         if (!req || ramstate == ACCESS) begin
            m_owner = 0;
         end else if (ramstate == ERROR || m_age == TMO - 1) begin
            m_owner = 0;
            m_err   = 1;
         end else begin
            m_age++;
         end
      end
      #1;
   endtask

   task automatic step();
      sample();
      tick();
   endtask

   int grants[$];
   int exp_order[6] = '{2, 2, 2, 2, 1, 2};
   int r;

   initial begin
      // ---- reset ----
      RST = 1;
      sample();
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick();
      RST = 0;

      // ---- icache read, BUSY x2 then ACCESS ----
      iREN = 1; iaddr = 32'h40; ramstate = BUSY;
      sample(); chk("i_idle_ramREN", 32'(ramREN), 32'd0); tick();
      sample(); chk("i_gnt_ramaddr", ramaddr, 32'h40); chk("i_busy_iwait", 32'(iwait), 32'd1); tick();
      step();
      ramstate = ACCESS; ramload = 32'hDEADBEEF;
      sample(); chk("i_acc_iwait", 32'(iwait), 32'd0); chk("i_acc_iload", iload, 32'hDEADBEEF); tick();
      iREN = 0; ramstate = FREE; ramload = 0;
      sample(); chk("i_done_state", 32'(dbg_state), 32'd0); tick();

      // ---- simultaneous icache read and dcache write ----
      iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'h1234;
      step();
      ramstate = ACCESS;
      sample(); chk("d_first_wen", 32'(ramWEN), 32'd1); chk("d_first_store", ramstore, 32'h1234); tick();
      dWEN = 0; ramstate = FREE;
      sample(); chk("gap_state", 32'(dbg_state), 32'd0); tick();
      ramstate = ACCESS; ramload = 32'h0BADF00D;
      sample(); chk("i_second_state", 32'(dbg_state), 32'd1); chk("i_second_addr", ramaddr, 32'h44); tick();
      iREN = 0; ramstate = FREE;
      step();

      // ---- starvation guard: dREN and iREN held, one-cycle accesses ----
      iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300; ramstate = ACCESS;
      for (int i = 0; i < 12; i++) begin
         ramload = $urandom;
         sample();
         if (dbg_state != 2'd0) grants.push_back(int'(dbg_state));
         tick();
      end
      chk("starve_ngrants", 32'(grants.size()), 32'd6);
      for (int k = 0; k < 6; k++)
         chk($sformatf("starve_order%0d", k), (k < grants.size()) ? 32'(grants[k]) : 32'd99, 32'(exp_order[k]));
      iREN = 0; dREN = 0; ramstate = FREE;
      step();

      // ---- dcache read hits ERROR; err stays sticky ----
      dREN = 1; daddr = 32'h500; ramload = 32'hAAAA5555;
      step();
      ramstate = ERROR;
      sample(); chk("derr_dwait", 32'(dwait), 32'd0); chk("derr_dload", dload, 32'd0); tick();
      dREN = 0; ramstate = FREE;
      sample(); chk("derr_err", 32'(err), 32'd1); tick();
      dREN = 1;
      step();
      ramstate = ACCESS;
      step();
      dREN = 0; ramstate = FREE;
      sample(); chk("err_sticky", 32'(err), 32'd1); tick();

      // ---- timeout with RAM stuck BUSY ----
      RST = 1; step(); RST = 0;
      dREN = 1; daddr = 32'h600; ramstate = BUSY;
      step();
      for (int i = 0; i < TMO; i++) begin
         sample(); chk("tmo_granted", 32'(dbg_state), 32'd2); tick();
      end
      sample();
      chk("tmo_idle", 32'(dbg_state), 32'd0);
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_dwait", 32'(dwait), 32'd1);
      tick();
      sample(); chk("tmo_regrant", 32'(dbg_state), 32'd2); tick();
      dREN = 0;
      step();

      // ---- reset in the middle of an icache grant ----
      iREN = 1; iaddr = 32'h80;
      step();
      sample(); chk("rstmid_gnt", 32'(dbg_state), 32'd1); tick();
      RST = 1;
      step();
      RST = 0;
      sample();
      chk("rstmid_ramREN", 32'(ramREN), 32'd0);
      chk("rstmid_err", 32'(err), 32'd0);
      chk("rstmid_state", 32'(dbg_state), 32'd0);
      tick();
      sample(); chk("rstmid_regrant", 32'(ramREN), 32'd1); tick();
      iREN = 0; ramstate = FREE;
      step();

      // ---- randomized traffic ----
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin iREN = 1'($urandom_range(0, 1)); iaddr = $urandom; end
         if ($urandom_range(0, 7) == 0) begin dREN = 1'($urandom_range(0, 1)); daddr = $urandom; end
         if ($urandom_range(0, 7) == 0) begin dWEN = 1'($urandom_range(0, 1)); dstore = $urandom; end
         r = int'($urandom_range(0, 9));
         ramstate = (r < 3) ? BUSY : (r < 5) ? FREE : (r < 9) ? ACCESS : ERROR;
         ramload = $urandom;
         RST = ($urandom_range(0, 63) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
